motor_interlock_gate: RTL

- Parametrised successor to the inline interlock compare in the fiber top level: gates the per-motor control word from the GBT stream onto the motor outputs.
- Outputs follow the stream only while a valid interlock key is present, fresh frames keep arriving, and the fiber is not in loopback.
- Adds an arming sequence, a frame-freshness watchdog, a per-motor enable mask and a sticky trip with a cause code.
- Sits between the GBT elink register and the motorControl outputs, in the GBT rx clock domain.

---
 rtl/motor_interlock_gate.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/motor_interlock_gate.sv
// Motor interlock gate: passes per-motor control words from the GBT stream to
// the motor outputs only while the interlock key is valid, frames keep
// arriving and no kill is asserted. Adds arming, a frame watchdog, a per-motor
// enable mask and a sticky trip with a cause code. Single clock domain.

package ckrs_pkg;
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;
endpackage

// One motor channel: output register that either shows the safe word or the
// last accepted control word for this motor.
module motor_interlock_lane #(
  parameter int                   CTRL_BITS = 4,
  parameter logic [CTRL_BITS-1:0] SAFE_WORD = '1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 safe_i,   // force safe word on next clock
  input  logic                 load_i,   // accept data_i on next clock
  input  logic [CTRL_BITS-1:0] data_i,
  output logic [CTRL_BITS-1:0] ctrl_o
);
  logic [CTRL_BITS-1:0] ctrl_q, ctrl_d;

  // Safe has priority over load so a masked or non-active motor never moves.
  always_comb begin
    ctrl_d = ctrl_q;
    if (safe_i)      ctrl_d = SAFE_WORD;
    else if (load_i) ctrl_d = data_i;
  end

  // Output register; reset drives the safe word immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ctrl_q <= SAFE_WORD;
    else       ctrl_q <= ctrl_d;
  end

  assign ctrl_o = ctrl_q;
endmodule

module motor_interlock_gate
  import ckrs_pkg::*;
#(
  parameter int                    g_Motors        = 16,
  parameter int                    g_CtrlBits      = 4,
  parameter logic [g_CtrlBits-1:0] g_SafeWord      = 4'hF,
  parameter logic [31:0]           g_Key           = 32'h0,
  parameter int                    g_ArmFrames     = 8,
  parameter int                    g_TimeoutCycles = 4000
) (
  input  ckrs_t                            ClkRs_ix,
  input  logic [g_Motors*g_CtrlBits-1:0]   ctrl_ib,
  input  logic                             ctrlValid_i,
  input  logic [31:0]                      key_ib32,
  input  logic                             loopback_i,
  input  logic                             forceSafe_i,
  input  logic                             clearTrip_i,
  input  logic [g_Motors-1:0]              mask_ib,
  output logic [g_Motors*g_CtrlBits-1:0]   ctrl_ob,
  output logic [1:0]                       state_ob2,
  output logic                             active_o,
  output logic [2:0]                       tripCause_ob3,
  output logic [15:0]                      frameCount_ob16
);
  localparam int ARM_W  = $clog2(g_ArmFrames + 1);
  localparam int WDOG_W = $clog2(g_TimeoutCycles);
  localparam logic [ARM_W-1:0]  ARM_DONE  = ARM_W'(g_ArmFrames);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(g_TimeoutCycles - 1);

  typedef enum logic [1:0] {
    ST_SAFE    = 2'd0,
    ST_ARMING  = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_TRIPPED = 2'd3
  } state_e;

  // The reset input is expected to be released synchronously upstream;
  // assertion acts asynchronously on every register here.
  logic clk, rst;
  assign clk = ClkRs_ix.clk;
  assign rst = ClkRs_ix.reset;

  state_e             state_q, state_d;
  logic [ARM_W-1:0]   arm_q, arm_d, arm_inc;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic [2:0]         cause_q, cause_d;
  logic [15:0]        fcnt_q, fcnt_d;

  logic key_ok, kill, running, expire, trip, load;

  assign key_ok  = (key_ib32 == g_Key);
  assign kill    = forceSafe_i | loopback_i;
  assign running = (state_q == ST_ARMING) || (state_q == ST_ACTIVE);
  // A strobe in the last watchdog cycle rescues the link.
  assign expire  = running && !ctrlValid_i && (wdog_q == WDOG_LAST);
  assign trip    = !key_ok || expire || kill;
  assign arm_inc = arm_q + ARM_W'(1);

  // Watchdog: cleared by every strobe and while idle/tripped.
  always_comb begin
    wdog_d = wdog_q + WDOG_W'(1);
    if (!running || ctrlValid_i || expire) wdog_d = '0;
  end

  // Interlock FSM: next state, arm counter, trip causes, strobe acceptance.
  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    cause_d = cause_q;
    load    = 1'b0;
    case (state_q)
      ST_SAFE: begin
        arm_d = '0;
        if (ctrlValid_i && key_ok && !kill) begin
          arm_d   = ARM_W'(1);
          state_d = (g_ArmFrames == 1) ? ST_ACTIVE : ST_ARMING;
        end
      end
      ST_ARMING: begin
        // Aborting arming is never a trip: it just starts over from SAFE.
        if (kill || expire) begin
          state_d = ST_SAFE;
          arm_d   = '0;
        end else if (ctrlValid_i) begin
          if (!key_ok) begin
            state_d = ST_SAFE;
            arm_d   = '0;
          end else begin
            arm_d = arm_inc;
            if (arm_inc == ARM_DONE) state_d = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        arm_d = '0;
        // A strobe coinciding with a trip is dropped.
        if (trip) begin
          state_d = ST_TRIPPED;
          cause_d = cause_q | {kill, expire, !key_ok};
        end else if (ctrlValid_i) begin
          load = 1'b1;
        end
      end
      ST_TRIPPED: begin
        arm_d = '0;
        if (clearTrip_i && !kill) begin
          state_d = ST_SAFE;
          cause_d = '0;
        end else begin
          // The watchdog is idle here, so only key and kill can add causes.
          cause_d = cause_q | {kill, 1'b0, !key_ok};
        end
      end
      default: begin
        state_d = ST_SAFE;
        arm_d   = '0;
      end
    endcase
  end

  // Accepted-frame counter, saturating.
  always_comb begin
    fcnt_d = fcnt_q;
    if (load && (fcnt_q != 16'hFFFF)) fcnt_d = fcnt_q + 16'd1;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SAFE;
      arm_q   <= '0;
      wdog_q  <= '0;
      cause_q <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      wdog_q  <= wdog_d;
      cause_q <= cause_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Per-motor output registers. Keying off the next state makes the outputs
  // go safe on the same edge the FSM leaves ACTIVE.
  for (genvar m = 0; m < g_Motors; m++) begin : gen_lane
    motor_interlock_lane #(
      .CTRL_BITS (g_CtrlBits),
      .SAFE_WORD (g_SafeWord)
    ) u_lane (
      .clk_i  (clk),
      .rst_i  (rst),
      .safe_i ((state_d != ST_ACTIVE) || !mask_ib[m]),
      .load_i (load),
      .data_i (ctrl_ib[m*g_CtrlBits +: g_CtrlBits]),
      .ctrl_o (ctrl_ob[m*g_CtrlBits +: g_CtrlBits])
    );
  end

  assign state_ob2       = state_q;
  assign active_o        = (state_q == ST_ACTIVE);
  assign tripCause_ob3   = cause_q;
  assign frameCount_ob16 = fcnt_q;
endmodule
